// File: rtl/smc_ahb_mcs_if.sv
// AHB-Lite slave front end of the static memory controller: bank decode,
// address-phase capture, two-cycle ERROR responses and an access watchdog.
module smc_ahb_mcs_if #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int NUM_CS      = 4,
    parameter int CS_IDX_W    = 2,
    parameter int CS_SEL_LSB  = 24,
    parameter int TIMEOUT_CYC = 256,
    parameter int TO_W        = 9
) (
    input  logic              hclk,
    input  logic              sys_reset,
    input  logic              hsel,
    input  logic [AW-1:0]     haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DW-1:0]     hwdata,
    input  logic              hready,
    output logic [DW-1:0]     smc_hrdata,
    output logic              smc_hready,
    output logic [1:0]        smc_hresp,
    output logic              smc_valid,
    input  logic [NUM_CS-1:0] cs_enable,
    input  logic [DW-1:0]     read_data,
    input  logic              smc_done,
    input  logic              mac_done,
    input  logic              smc_idle,
    output logic              new_access,
    output logic [AW-1:0]     addr,
    output logic [NUM_CS-1:0] cs,
    output logic [1:0]        xfer_size,
    output logic              n_read,
    output logic [DW-1:0]     write_data,
    output logic              smc_abort
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;

    state_t              state;
    logic [TO_W-1:0]     to_cnt;
    logic                av_p0;
    logic                err_p0;
    logic [CS_IDX_W-1:0] cs_idx_p0;
    logic [NUM_CS-1:0]   cs_onehot_p0;
    logic                done;
    logic                decode_ok;
    logic                timeout;
    logic                unused_ok;

    // Only 32-bit data is supported, so anything wider than a word is illegal.
    function automatic logic align_err(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'b000:  align_err = 1'b0;
            3'b001:  align_err = lsb[0];
            3'b010:  align_err = |lsb;
            default: align_err = 1'b1;
        endcase
    endfunction

    // Address-phase decode
    assign av_p0        = hsel & hready & htrans[1];
    assign cs_idx_p0    = haddr[CS_SEL_LSB +: CS_IDX_W];
    assign cs_onehot_p0 = {{(NUM_CS-1){1'b0}}, 1'b1} << cs_idx_p0;
    assign err_p0       = align_err(hsize, haddr[1:0]) | ~cs_enable[cs_idx_p0];
    assign smc_valid    = av_p0 & ~err_p0;

    assign done       = smc_done & mac_done;
    assign decode_ok  = (state == S_IDLE) || (state == S_ERR2) || ((state == S_ACCESS) && done);
    assign timeout    = (TIMEOUT_CYC != 0) && (state == S_ACCESS) && !done &&
                        (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign smc_hrdata = read_data;
    assign unused_ok  = ^{smc_idle, htrans[0]};

    always_comb begin
        smc_hready = 1'b1;
        smc_hresp  = 2'b00;
        case (state)
            S_ACCESS: smc_hready = done;
            S_ERR1: begin
                smc_hready = 1'b0;
                smc_hresp  = 2'b01;
            end
            S_ERR2:   smc_hresp = 2'b01;
            default: ;
        endcase
    end

    // Access control and watchdog
    always_ff @(posedge hclk) begin
        if (sys_reset) begin
            state      <= S_IDLE;
            cs         <= '0;
            new_access <= 1'b0;
            addr       <= '0;
            xfer_size  <= '0;
            n_read     <= 1'b1;
            write_data <= '0;
            smc_abort  <= 1'b0;
            to_cnt     <= '0;
        end else begin
            new_access <= 1'b0;
            smc_abort  <= 1'b0;
            // new_access is high exactly in the first ACCESS cycle, when hwdata is valid.
            if (state == S_ACCESS && new_access)
                write_data <= hwdata;
            case (state)
                S_ACCESS: begin
                    if (done) begin
                        to_cnt <= '0;
                    end else if (timeout) begin
                        smc_abort <= 1'b1;
                        cs        <= '0;
                        to_cnt    <= '0;
                        state     <= S_ERR1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_ERR1:  state <= S_ERR2;
                default: ;
            endcase
            if (decode_ok) begin
                if (av_p0 && !err_p0) begin
                    addr       <= haddr;
                    xfer_size  <= hsize[1:0];
                    n_read     <= hwrite;
                    cs         <= cs_onehot_p0;
                    new_access <= 1'b1;
                    to_cnt     <= '0;
                    state      <= S_ACCESS;
                end else if (av_p0) begin
                    cs    <= '0;
                    state <= S_ERR1;
                end else begin
                    cs    <= '0;
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_smc_ahb_mcs_if.sv
// Randomised scoreboard bench for smc_ahb_mcs_if with a transaction-level
// reference model; a monitor pops expectations on new_access and ERROR cycles.
module tb_smc_ahb_mcs_if;

    localparam int TO = 8;
    localparam int N  = 160;

    typedef struct {
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
        logic [31:0] data;
        logic [3:0]  cs_en;
        int          d;      // ACCESS cycle carrying done, 0 = never
        bit          pipe;   // presented in the previous done / ERR2 cycle
        bit          seq;
    } xfer_t;

    typedef struct {
        bit          is_err;
        bit          abort;
        logic [31:0] addr;
        logic [3:0]  cs;
        logic [1:0]  xsize;
        logic        n_read;
        logic [31:0] wdata;
    } exp_t;

    logic        hclk = 1'b0;
    logic        sys_reset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic [31:0] smc_hrdata;
    logic        smc_hready;
    logic [1:0]  smc_hresp;
    logic        smc_valid;
    logic [3:0]  cs_enable = 4'hF;
    logic [31:0] read_data = '0;
    logic        smc_done = 1'b0;
    logic        mac_done = 1'b0;
    logic        smc_idle = 1'b0;
    logic        new_access;
    logic [31:0] addr;
    logic [3:0]  cs;
    logic [1:0]  xfer_size;
    logic        n_read;
    logic [31:0] write_data;
    logic        smc_abort;

    int   n_vec = 0;
    int   n_miss = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    bit   chk_valid = 1'b0, exp_valid = 1'b0;
    bit   chk_hready = 1'b0, exp_hready = 1'b0;
    xfer_t tr[N];

    assign hready = smc_hready;

    always #5 hclk = ~hclk;

    smc_ahb_mcs_if #(.TIMEOUT_CYC(TO), .TO_W(4)) dut (
        .hclk(hclk), .sys_reset(sys_reset), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .smc_hrdata(smc_hrdata), .smc_hready(smc_hready),
        .smc_hresp(smc_hresp), .smc_valid(smc_valid), .cs_enable(cs_enable),
        .read_data(read_data), .smc_done(smc_done), .mac_done(mac_done),
        .smc_idle(smc_idle), .new_access(new_access), .addr(addr), .cs(cs),
        .xfer_size(xfer_size), .n_read(n_read), .write_data(write_data),
        .smc_abort(smc_abort)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    // Reference model: legality from byte alignment and bank enable.
    function automatic int bank_of(input logic [31:0] a);
        return int'((a >> 24) % 4);
    endfunction

    function automatic bit model_err(input xfer_t t);
        int nbytes;
        if (t.hsize > 3'd2) return 1'b1;
        nbytes = 1 << t.hsize;
        if ((t.haddr % nbytes) != 0) return 1'b1;
        return !t.cs_en[bank_of(t.haddr)];
    endfunction

    function automatic bit model_timeout(input xfer_t t);
        return !model_err(t) && (t.d == 0 || t.d > TO);
    endfunction

    function automatic xfer_t mk(input logic [31:0] a, input int sz, input bit wr,
                                 input logic [3:0] en, input int d, input bit pipe, input bit seq);
        xfer_t t;
        t.haddr = a; t.hsize = 3'(sz); t.hwrite = wr; t.data = $urandom;
        t.cs_en = en; t.d = d; t.pipe = pipe; t.seq = seq;
        return t;
    endfunction

    function automatic xfer_t gen_rand();
        xfer_t t;
        int sz, d;
        case ($urandom % 7)
            0: sz = 0;  1: sz = 1;  5: sz = 3;  6: sz = 5;
            default: sz = 2;
        endcase
        case ($urandom % 8)
            6: d = 0;  7: d = 8;
            default: d = 1 + int'($urandom % 5);
        endcase
        t = mk($urandom & 32'h03FF_FFFC, sz, 1'($urandom), 4'hF, d, 1'($urandom), 1'b0);
        if ($urandom % 4 == 0) t.haddr = t.haddr | ($urandom % 4);
        if ($urandom % 4 == 0) t.cs_en = 4'($urandom);
        t.seq = t.pipe & 1'($urandom);
        return t;
    endfunction

    task automatic step();
        read_data = $urandom;
        smc_idle  = 1'($urandom);
        @(negedge hclk);
        if (chk_valid) check("smc_valid", 32'(smc_valid), 32'(exp_valid));
        if (chk_hready) begin
            check("access_hready", 32'(smc_hready), 32'(exp_hready));
            check("access_hresp", 32'(smc_hresp), 32'd0);
        end
        chk_valid  = 1'b0;
        chk_hready = 1'b0;
        @(posedge hclk);
        #1;
    endtask

    task automatic present(input xfer_t t);
        exp_t e;
        logic [3:0] c;
        cs_enable = t.cs_en;
        hsel   = 1'b1;
        htrans = t.seq ? 2'b11 : 2'b10;
        haddr  = t.haddr;
        hsize  = t.hsize;
        hwrite = t.hwrite;
        chk_valid = 1'b1;
        exp_valid = !model_err(t);
        e.abort = 1'b0; e.addr = t.haddr; e.xsize = t.hsize[1:0];
        e.n_read = t.hwrite; e.wdata = t.data;
        c = '0;
        c[bank_of(t.haddr)] = 1'b1;
        e.cs = c;
        e.is_err = model_err(t);
        exp_q.push_back(e);
        if (model_timeout(t)) begin
            e.is_err = 1'b1;
            e.abort  = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_bus();
        hsel = 1'b0; htrans = 2'b00; smc_done = 1'b0; mac_done = 1'b0;
    endtask

    task automatic check_reset(input string p);
        check({p, "_hready"}, 32'(smc_hready), 32'd1);
        check({p, "_hresp"}, 32'(smc_hresp), 32'd0);
        check({p, "_cs"}, 32'(cs), 32'd0);
        check({p, "_new_access"}, 32'(new_access), 32'd0);
        check({p, "_addr"}, addr, 32'd0);
        check({p, "_xfer_size"}, 32'(xfer_size), 32'd0);
        check({p, "_n_read"}, 32'(n_read), 32'd1);
        check({p, "_write_data"}, write_data, 32'd0);
        check({p, "_abort"}, 32'(smc_abort), 32'd0);
    endtask

    // Monitor: pops one expectation per started access and per ERROR response.
    bit          wd_chk = 1'b0, err2_chk = 1'b0;
    logic [31:0] wd_exp = '0;
    always @(negedge hclk) begin : mon
        exp_t e;
        bit   in_err1;
        if (mon_en && !sys_reset) begin
            in_err1 = (smc_hready === 1'b0) && (smc_hresp === 2'b01);
            check("hrdata", smc_hrdata, read_data);
            check("cs_onehot0", 32'($onehot0(cs)), 32'd1);
            if (wd_chk) begin
                check("write_data", write_data, wd_exp);
                wd_chk = 1'b0;
            end
            if (new_access === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    check("unexpected_new_access", 32'(new_access), 32'd0);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    e = exp_q.pop_front();
                    check("addr", addr, e.addr);
                    check("cs", 32'(cs), 32'(e.cs));
                    check("xfer_size", 32'(xfer_size), 32'(e.xsize));
                    check("n_read", 32'(n_read), 32'(e.n_read));
                    wd_exp = e.wdata;
                    wd_chk = 1'b1;
                end
            end
            if (in_err1) begin
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    check("unexpected_err1", 32'(smc_hresp), 32'd0);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    e = exp_q.pop_front();
                    check("err1_abort", 32'(smc_abort), 32'(e.abort));
                end
                check("err1_cs", 32'(cs), 32'd0);
                check("err1_new_access", 32'(new_access), 32'd0);
                err2_chk = 1'b1;
            end else begin
                check("abort_outside_err1", 32'(smc_abort), 32'd0);
                if (err2_chk) begin
                    check("err2_hready", 32'(smc_hready), 32'd1);
                    check("err2_hresp", 32'(smc_hresp), 32'd1);
                    check("err2_new_access", 32'(new_access), 32'd0);
                    err2_chk = 1'b0;
                end
            end
        end else begin
            wd_chk   = 1'b0;
            err2_chk = 1'b0;
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin : drive
        bit presented;
        tr[0] = mk(32'h0100_0004, 2, 1'b0, 4'hF, 4, 1'b0, 1'b0);
        tr[1] = mk(32'h0000_0003, 1, 1'b1, 4'hF, 1, 1'b0, 1'b0);
        tr[2] = mk(32'h0200_0000, 2, 1'b0, 4'b1011, 1, 1'b0, 1'b0);
        tr[3] = mk(32'h0300_0000, 2, 1'b0, 4'b1011, 2, 1'b1, 1'b0);
        tr[4] = mk(32'h0000_0010, 2, 1'b1, 4'hF, 1, 1'b0, 1'b0);
        tr[5] = mk(32'h0000_0014, 2, 1'b1, 4'hF, 2, 1'b1, 1'b1);
        tr[6] = mk(32'h0000_0018, 2, 1'b1, 4'hF, 0, 1'b1, 1'b1);
        tr[7] = mk(32'h0100_0020, 2, 1'b0, 4'hF, 8, 1'b0, 1'b0);
        tr[8] = mk(32'h0200_0003, 0, 1'b1, 4'hF, 3, 1'b0, 1'b0);
        tr[9] = mk(32'h0200_0008, 3, 1'b0, 4'hF, 1, 1'b1, 1'b0);
        for (int i = 10; i < N; i++) tr[i] = gen_rand();

        repeat (3) step();
        sys_reset = 1'b0;
        @(negedge hclk);
        check_reset("init");
        mon_en = 1'b1;
        @(posedge hclk);
        #1;

        presented = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!presented) begin
                if ($urandom % 3 == 0) begin
                    hsel = 1'($urandom); htrans = 2'($urandom % 2); haddr = $urandom;
                    chk_valid = 1'b1; exp_valid = 1'b0;
                    step();
                end
                present(tr[i]);
            end
            presented = 1'b0;
            step();
            idle_bus();
            hwdata = tr[i].data;
            if (model_err(tr[i])) begin
                step();
            end else begin
                for (int k = 1; k <= TO; k++) begin
                    smc_done   = (k == tr[i].d);
                    mac_done   = (k == tr[i].d) | 1'($urandom);
                    chk_hready = 1'b1;
                    exp_hready = (k == tr[i].d);
                    if (k == tr[i].d) break;
                    step();
                    idle_bus();
                    if (k == TO) step();
                end
            end
            if (i + 1 < N && tr[i+1].pipe) begin
                present(tr[i+1]);
                presented = 1'b1;
            end else begin
                step();
                idle_bus();
            end
        end
        repeat (2) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the second ACCESS cycle abandons the access without an abort.
        present(mk(32'h0300_0008, 2, 1'b0, 4'hF, 3, 1'b0, 1'b0));
        step();
        idle_bus();
        hwdata = 32'hA5A5_5A5A;
        chk_hready = 1'b1; exp_hready = 1'b0;
        step();
        sys_reset = 1'b1;
        step();
        sys_reset = 1'b0;
        @(negedge hclk);
        check_reset("post_rst");
        check("queue_after_rst", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
